// File: rtl/pixel_packer_if.sv
// Pixel-in / AXI4-Stream-out bundle for pixel_packer. The packer uses the master
// modport (it sources the stream); the pixel buffer / DMA side uses slave.
`timescale 1ns/1ps
interface pixel_packer_if;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;

  modport master (
    input  in_r, in_g, in_b, in_valid, out_stream_tready,
    output in_ready, out_stream_tdata, out_stream_tkeep,
           out_stream_tlast, out_stream_tuser, out_stream_tvalid
  );

  modport slave (
    output in_r, in_g, in_b, in_valid, out_stream_tready,
    input  in_ready, out_stream_tdata, out_stream_tkeep,
           out_stream_tlast, out_stream_tuser, out_stream_tvalid
  );
endinterface

// File: rtl/pixel_packer.sv
// Packs 4 x 24-bit RGB pixels into 3 x 32-bit AXI4-Stream words with SOF (tuser) / EOL (tlast).
// Optional frame counter port enabled by defining PACKER_FRAME_CNT_EN.
`timescale 1ns/1ps
module pixel_packer #(
  parameter int unsigned X_SIZE = 640,
  parameter int unsigned Y_SIZE = 480
) (
  input  logic           aclk,
  input  logic           aresetn,
  pixel_packer_if.master bus
`ifdef PACKER_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_count
`endif
);

  localparam int unsigned XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

  generate
    if ((X_SIZE % 4) != 0) begin : g_bad_x_size
      $error("pixel_packer: X_SIZE must be a multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e      phase_q, phase_d;
  logic [23:0] pix;
  logic [23:0] partial_q, partial_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic        x_last, y_last;
  logic        accept;

  logic        word_en;
  logic [31:0] word;
  logic        word_tuser, word_tlast;

  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;

  assign pix    = {bus.in_r, bus.in_g, bus.in_b};
  assign accept = bus.in_valid && bus.in_ready;
  assign x_last = (x_q == XW'(X_SIZE - 1));
  assign y_last = (y_q == YW'(Y_SIZE - 1));

  assign bus.in_ready          = !tvalid_q || bus.out_stream_tready;
  assign bus.out_stream_tdata  = tdata_q;
  assign bus.out_stream_tkeep  = 4'hF;
  assign bus.out_stream_tlast  = tlast_q;
  assign bus.out_stream_tuser  = tuser_q;
  assign bus.out_stream_tvalid = tvalid_q;

  // Phase FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q <= PH0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase FSM: next state, advancing only on an accepted pixel
  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      unique case (phase_q)
        PH0:     phase_d = PH1;
        PH1:     phase_d = PH2;
        PH2:     phase_d = PH3;
        PH3:     phase_d = PH0;
        default: phase_d = PH0;
      endcase
    end
  end

  // Phase FSM: word assembly and leftover-byte bookkeeping
  always_comb begin
    word_en    = 1'b0;
    word       = '0;
    word_tuser = 1'b0;
    word_tlast = 1'b0;
    partial_d  = partial_q;
    if (accept) begin
      unique case (phase_q)
        PH0: begin
          partial_d = pix;
        end
        PH1: begin
          word_en         = 1'b1;
          word            = {pix[7:0], partial_q};
          partial_d[15:0] = pix[23:8];
          word_tuser      = (x_q == XW'(1)) && (y_q == '0);
        end
        PH2: begin
          word_en        = 1'b1;
          word           = {pix[15:0], partial_q[15:0]};
          partial_d[7:0] = pix[23:16];
        end
        PH3: begin
          word_en    = 1'b1;
          word       = {pix, partial_q[7:0]};
          word_tlast = x_last;
        end
        default: ;
      endcase
    end
  end

  // Raster position, stepped once per accepted pixel
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // A new word always wins over a pop, giving back-to-back transfers
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (word_en) begin
      tdata_d  = word;
      tvalid_d = 1'b1;
      tlast_d  = word_tlast;
      tuser_d  = word_tuser;
    end else if (bus.out_stream_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      partial_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
    end else begin
      partial_q <= partial_d;
      x_q       <= x_d;
      y_q       <= y_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
    end
  end

`ifdef PACKER_FRAME_CNT_EN
  // Remembers whether the held word closes the frame, so the count moves on its pop
  logic        fend_q, fend_d;
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fend_d = fend_q;
    fcnt_d = fcnt_q;
    if (word_en) begin
      fend_d = word_tlast && y_last;
    end
    if (tvalid_q && bus.out_stream_tready && tlast_q && fend_q) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fend_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      fend_q <= fend_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer: directed scenarios on a 4x2 instance and a
// randomized stall run on an 8x2 instance, checked against a byte-stream reference model.
`timescale 1ns/1ps
module tb_pixel_packer;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  pixel_packer_if bus_a ();
  pixel_packer_if bus_b ();

`ifdef PACKER_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  pixel_packer #(.X_SIZE(4), .Y_SIZE(2)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_a)
`ifdef PACKER_FRAME_CNT_EN
    , .frame_count(fc_a)
`endif
  );

  pixel_packer #(.X_SIZE(8), .Y_SIZE(2)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_b)
`ifdef PACKER_FRAME_CNT_EN
    , .frame_count(fc_b)
`endif
  );

  typedef struct {
    logic [31:0] data;
    bit          tuser;
    bit          tlast;
    bit          fend;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        log_q[$];
  logic [7:0]  bytes_q[$];
  int unsigned wc;
  int unsigned fc_m;
  int unsigned cur;
  int unsigned xs, ys;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    log_q.delete();
    bytes_q.delete();
    wc   = 0;
    fc_m = 0;
  endtask

  // Pixels form a little-endian byte stream; every 4 bytes is one output word
  task automatic model_accept(input logic [23:0] p);
    exp_t        e;
    int unsigned wpl, wpf;
    wpl = xs * 3 / 4;
    wpf = wpl * ys;
    bytes_q.push_back(p[7:0]);
    bytes_q.push_back(p[15:8]);
    bytes_q.push_back(p[23:16]);
    while (bytes_q.size() >= 4) begin
      e.data  = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};
      repeat (4) void'(bytes_q.pop_front());
      e.tuser = (wc == 0);
      e.tlast = ((wc + 1) % wpl) == 0;
      e.fend  = (wc + 1) == wpf;
      wc      = e.fend ? 0 : wc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    bus_a.in_valid = 1'b0; bus_a.out_stream_tready = 1'b1;
    bus_a.in_r = '0; bus_a.in_g = '0; bus_a.in_b = '0;
    bus_b.in_valid = 1'b0; bus_b.out_stream_tready = 1'b1;
    bus_b.in_r = '0; bus_b.in_g = '0; bus_b.in_b = '0;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, compare, then advance
  task automatic cycle(input bit v, input logic [23:0] p, input bit rdy, output bit acc);
    logic        tv, tl, tu, ir;
    logic [3:0]  tk;
    logic [31:0] td;
    logic [15:0] fc;
    bit          exp_ir;
    exp_t        e;
    fc = '0;
    if (cur == 0) begin
      bus_a.in_valid = v; {bus_a.in_r, bus_a.in_g, bus_a.in_b} = p; bus_a.out_stream_tready = rdy;
    end else begin
      bus_b.in_valid = v; {bus_b.in_r, bus_b.in_g, bus_b.in_b} = p; bus_b.out_stream_tready = rdy;
    end
    #1;
    if (cur == 0) begin
      tv = bus_a.out_stream_tvalid; tl = bus_a.out_stream_tlast; tu = bus_a.out_stream_tuser;
      td = bus_a.out_stream_tdata;  tk = bus_a.out_stream_tkeep; ir = bus_a.in_ready;
`ifdef PACKER_FRAME_CNT_EN
      fc = fc_a;
`endif
    end else begin
      tv = bus_b.out_stream_tvalid; tl = bus_b.out_stream_tlast; tu = bus_b.out_stream_tuser;
      td = bus_b.out_stream_tdata;  tk = bus_b.out_stream_tkeep; ir = bus_b.in_ready;
`ifdef PACKER_FRAME_CNT_EN
      fc = fc_b;
`endif
    end
    chk("tvalid", tv, exp_q.size() != 0);
    chk("tkeep", tk, 4'hF);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("tdata", td, e.data);
      chk("tuser", tu, e.tuser);
      chk("tlast", tl, e.tlast);
    end
    exp_ir = (exp_q.size() == 0) || rdy;
    chk("in_ready", ir, exp_ir);
`ifdef PACKER_FRAME_CNT_EN
    chk("frame_count", fc, fc_m);
`endif
    if (exp_q.size() != 0 && rdy) begin
      e = exp_q.pop_front();
      log_q.push_back(e);
      if (e.fend) fc_m = (fc_m + 1) & 32'hFFFF;
    end
    acc = v && exp_ir;
    if (acc) model_accept(p);
    @(negedge aclk);
  endtask

  task automatic send(input logic [23:0] p);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, p, 1'b1, acc);
    chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 4; i++) cycle(1'b0, 24'h0, 1'b1, acc);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle_inputs();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    @(negedge aclk);
  endtask

  task automatic check_s2(input string tag);
    logic [31:0] w[3];
    w[0] = 32'h66112233; w[1] = 32'h88994455; w[2] = 32'hAABBCC77;
    chk({tag, "_count"}, log_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_q.size()) begin
        chk({tag, "_data"}, log_q[i].data, w[i]);
        chk({tag, "_tuser"}, log_q[i].tuser, i == 0);
        chk({tag, "_tlast"}, log_q[i].tlast, i == 2);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [23:0] s2[4];
    logic [23:0] pix;
    int unsigned sent, cycles;

    s2[0] = 24'h112233; s2[1] = 24'h445566; s2[2] = 24'h778899; s2[3] = 24'hAABBCC;
    cur = 0; xs = 4; ys = 2;
    model_reset();
    idle_inputs();

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      bus_a.in_valid = i[0];
      {bus_a.in_r, bus_a.in_g, bus_a.in_b} = $urandom;
      bus_a.out_stream_tready = i[1];
      #1;
      chk("rst_tvalid", bus_a.out_stream_tvalid, 1'b0);
      chk("rst_tlast", bus_a.out_stream_tlast, 1'b0);
      chk("rst_tuser", bus_a.out_stream_tuser, 1'b0);
      chk("rst_tdata", bus_a.out_stream_tdata, 32'h0);
      chk("rst_in_ready", bus_a.in_ready, 1'b1);
    end
    do_reset();

    // Basic packing, tready held high
    for (int i = 0; i < 4; i++) send(s2[i]);
    drain();
    check_s2("pack");

    // Backpressure after the first word
    do_reset();
    send(s2[0]);
    send(s2[1]);
    for (int i = 0; i < 4; i++) cycle(1'b1, s2[2], 1'b0, acc);
    send(s2[2]);
    send(s2[3]);
    drain();
    check_s2("bp");

    // Three lines: crosses one frame boundary
    do_reset();
    for (int i = 0; i < 12; i++) send(24'($urandom));
    drain();
    chk("wrap_count", log_q.size(), 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++) begin
      chk("wrap_tlast", log_q[i].tlast, (i == 2) || (i == 5) || (i == 8));
      chk("wrap_tuser", log_q[i].tuser, (i == 0) || (i == 6));
    end
`ifdef PACKER_FRAME_CNT_EN
    chk("wrap_frame_count", fc_a, 16'd1);
`endif

    // Reset in the middle of a group
    do_reset();
    send(24'hDEADBE);
    send(24'hC0FFEE);
    do_reset();
    for (int i = 0; i < 4; i++) send(s2[i]);
    drain();
    check_s2("midrst");

    // Random stall run on the 8-pixel-wide instance, 10 frames
    cur = 1; xs = 8; ys = 2;
    do_reset();
    sent = 0;
    cycles = 0;
    pix = 24'($urandom);
    while (sent < 160 && cycles < 20000) begin
      cycle($urandom_range(0, 3) != 0, pix, $urandom_range(0, 3) != 0, acc);
      if (acc) begin
        sent++;
        pix = 24'($urandom);
      end
      cycles++;
    end
    chk("rand_all_sent", sent, 160);
    drain();
    chk("rand_words", log_q.size(), 120);
    chk("rand_pending", exp_q.size(), 0);
    chk("rand_bytes_left", bytes_q.size(), 0);
`ifdef PACKER_FRAME_CNT_EN
    chk("rand_frame_count", fc_b, 16'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
